// File: rtl/vector_sweep_if.sv
// Bus between the sweep checker and its environment: control, driven vector,
// compared outputs and result reporting.
interface vector_sweep_if #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  vec_out;
  logic [OUT_W-1:0] dut_in;
  logic [OUT_W-1:0] exp_in;
  logic             sample_strobe;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [IN_W-1:0]  first_err_vec;
  logic             first_err_valid;

  modport master (
    input  start, abort, dut_in, exp_in,
    output vec_out, sample_strobe, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, abort, dut_in, exp_in,
    input  vec_out, sample_strobe, busy, done, pass,
           err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/vector_sweep_checker.sv
// Exhaustive input sweep engine: drives every IN_W-bit vector for HOLD cycles,
// compares DUT against golden outputs on the last hold cycle, reports results.
module vector_sweep_checker #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned HOLD  = 10,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  vector_sweep_if.master bus
);

  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [IN_W-1:0]   fev_q, fev_d;
  logic              fevalid_q, fevalid_d;
  logic              cmp_c;
  logic              mismatch_c;

  // Compare cycle is decoded from registered state only
  assign cmp_c      = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
  assign mismatch_c = cmp_c && (bus.dut_in != bus.exp_in);

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fevalid_d = fevalid_q;

    if (bus.abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d   = S_DRIVE;
            vec_d     = '0;
            hold_d    = '0;
            pass_d    = 1'b0;
            err_d     = '0;
            fev_d     = '0;
            fevalid_d = 1'b0;
          end
        end
        S_DRIVE: begin
          if (cmp_c) begin
            if (mismatch_c) begin
              if (err_q != '1) err_d = err_q + 1'b1;
              if (!fevalid_q) begin
                fev_d     = vec_q;
                fevalid_d = 1'b1;
              end
            end
            // Final mismatch is already folded into err_d before pass is taken
            if (vec_q == '1) begin
              state_d = S_DONE;
              pass_d  = (err_d == '0);
            end else begin
              vec_d  = vec_q + 1'b1;
              hold_d = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    strobe_d = (state_d == S_DRIVE) && (hold_d == HOLD_LAST);
    busy_d   = (state_d == S_DRIVE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      hold_q    <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fev_q     <= '0;
      fevalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fev_q     <= fev_d;
      fevalid_q <= fevalid_d;
    end
  end

  assign bus.vec_out         = vec_q;
  assign bus.sample_strobe   = strobe_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevalid_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Bench for vector_sweep_checker: three configurations, table and random
// mismatch patterns against an arithmetic reference model, plus corner sequences.
module tb_vector_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main: IN_W=3 HOLD=10 CNT_W=16; sat: CNT_W=2; fast: IN_W=4 HOLD=1
  vector_sweep_if #(.IN_W(3), .OUT_W(2), .CNT_W(16)) ifa ();
  vector_sweep_if #(.IN_W(3), .OUT_W(2), .CNT_W(2))  ifs ();
  vector_sweep_if #(.IN_W(4), .OUT_W(2), .CNT_W(16)) ifq ();

  vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD(10), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master));
  vector_sweep_checker #(.IN_W(3), .OUT_W(2), .HOLD(10), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs.master));
  vector_sweep_checker #(.IN_W(4), .OUT_W(2), .HOLD(1), .CNT_W(16)) u_q (
    .clk(clk), .rst_n(rst_n), .bus(ifq.master));

  logic [1:0]  dtab_a [8];
  logic [7:0]  bad_a;
  logic [1:0]  flip_a;
  logic [15:0] bad_q;

  assign ifa.dut_in = dtab_a[ifa.vec_out];
  assign ifa.exp_in = dtab_a[ifa.vec_out] ^ (bad_a[ifa.vec_out] ? flip_a : 2'b00);
  assign ifs.dut_in = ifs.vec_out[1:0];
  assign ifs.exp_in = ~ifs.vec_out[1:0];
  assign ifq.dut_in = ifq.vec_out[1:0];
  assign ifq.exp_in = ifq.vec_out[1:0] ^ {1'b0, bad_q[ifq.vec_out]};

  typedef struct {
    logic [7:0]  bad;
    bit          mid;
    int unsigned err;
    int unsigned fev;
    bit          fvalid;
    bit          pass;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: results follow directly from which vectors disagree
  function automatic void ref_model(input logic [7:0] bad, input int unsigned cnt_w,
                                    output int unsigned err, output int unsigned fev,
                                    output bit valid);
    err = 0; fev = 0; valid = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (bad[v]) begin
        if (!valid) begin fev = v; valid = 1'b1; end
        err++;
      end
    end
    if (err > (32'd1 << cnt_w) - 1) err = (32'd1 << cnt_w) - 1;
  endfunction

  task automatic start_a();
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
  endtask

  // Full sweep on the main instance with cycle-accurate trace check
  task automatic run_a(input string tag, input logic [7:0] bad, input bit mid,
                       input int unsigned e_err, input int unsigned e_fev,
                       input bit e_valid, input bit e_pass);
    int bad_cyc;
    int first_bad;
    int exp_vec;
    bit exp_strb, exp_busy, exp_done;
    bad_a  = bad;
    flip_a = 2'($urandom_range(1, 3));
    for (int v = 0; v < 8; v++) dtab_a[v] = 2'($urandom);
    start_a();
    check({tag, ".clr_err"}, 64'(ifa.err_count), 64'd0);
    bad_cyc = 0; first_bad = -1;
    for (int t = 0; t <= 80; t++) begin
      exp_vec  = (t < 80) ? t / 10 : 7;
      exp_strb = (t < 80) && (t % 10 == 9);
      exp_busy = (t < 80);
      exp_done = (t == 80);
      if (ifa.vec_out !== 3'(exp_vec) || ifa.sample_strobe !== exp_strb ||
          ifa.busy !== exp_busy || ifa.done !== exp_done) begin
        bad_cyc++;
        if (first_bad < 0) first_bad = t;
      end
      if (t < 80) begin
        if (mid && t == 33) ifa.start = 1'b1;
        else ifa.start = 1'b0;
        @(negedge clk);
      end
    end
    ifa.start = 1'b0;
    if (first_bad >= 0) $display("  %s trace first deviates at cycle %0d", tag, first_bad);
    check({tag, ".trace"},  64'(bad_cyc), 64'd0);
    check({tag, ".err"},    64'(ifa.err_count), 64'(e_err));
    check({tag, ".fev"},    64'(ifa.first_err_vec), 64'(e_fev));
    check({tag, ".fvalid"}, 64'(ifa.first_err_valid), 64'(e_valid));
    check({tag, ".pass"},   64'(ifa.pass), 64'(e_pass));
  endtask

  vec_t tbl [6];

  initial begin
    int unsigned r_err, r_fev;
    bit r_valid;
    logic [7:0] r_bad;
    int cnt;

    ifa.start = 0; ifa.abort = 0;
    ifs.start = 0; ifs.abort = 0;
    ifq.start = 0; ifq.abort = 0;
    bad_a = '0; flip_a = 2'b01; bad_q = '0;
    for (int v = 0; v < 8; v++) dtab_a[v] = 2'($urandom);
    rst_n = 1'b0;

    tbl[0] = '{bad: 8'h00, mid: 1'b0, err: 0, fev: 0, fvalid: 1'b0, pass: 1'b1};
    tbl[1] = '{bad: 8'h60, mid: 1'b0, err: 2, fev: 5, fvalid: 1'b1, pass: 1'b0};
    tbl[2] = '{bad: 8'hFF, mid: 1'b0, err: 8, fev: 0, fvalid: 1'b1, pass: 1'b0};
    tbl[3] = '{bad: 8'h80, mid: 1'b0, err: 1, fev: 7, fvalid: 1'b1, pass: 1'b0};
    tbl[4] = '{bad: 8'h00, mid: 1'b1, err: 0, fev: 0, fvalid: 1'b0, pass: 1'b1};
    tbl[5] = '{bad: 8'h14, mid: 1'b1, err: 2, fev: 2, fvalid: 1'b1, pass: 1'b0};

    #12;
    check("rst.vec",  64'(ifa.vec_out), 64'd0);
    check("rst.flags", 64'({ifa.busy, ifa.done, ifa.pass, ifa.sample_strobe, ifa.first_err_valid}), 64'd0);
    check("rst.err",  64'(ifa.err_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_a($sformatf("tbl%0d", i), tbl[i].bad, tbl[i].mid, tbl[i].err, tbl[i].fev,
            tbl[i].fvalid, tbl[i].pass);

    for (int i = 0; i < 6; i++) begin
      r_bad = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ref_model(r_bad, 16, r_err, r_fev, r_valid);
      run_a($sformatf("rnd%0d", i), r_bad, 1'($urandom), r_err, r_fev, r_valid, (r_err == 0));
    end

    // Asynchronous reset in the middle of vector 3
    bad_a = 8'h02;
    start_a();
    repeat (37) @(negedge clk);
    check("prerst.err", 64'(ifa.err_count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.vec",  64'(ifa.vec_out), 64'd0);
    check("midrst.err",  64'(ifa.err_count), 64'd0);
    check("midrst.fev",  64'({ifa.first_err_valid, ifa.first_err_vec}), 64'd0);
    check("midrst.flags", 64'({ifa.busy, ifa.done, ifa.pass, ifa.sample_strobe}), 64'd0);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin @(negedge clk); if (ifa.done || ifa.busy) cnt++; end
    check("midrst.no_done", 64'(cnt), 64'd0);
    run_a("postrst", 8'h00, 1'b0, 0, 0, 1'b0, 1'b1);

    // Abort during vector 2 keeps debug state
    bad_a = 8'h02;
    start_a();
    repeat (25) @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk); ifa.abort = 1'b0;
    check("abort.flags", 64'({ifa.busy, ifa.done, ifa.pass, ifa.sample_strobe}), 64'd0);
    check("abort.vec",   64'(ifa.vec_out), 64'd2);
    check("abort.err",   64'(ifa.err_count), 64'd1);
    check("abort.fev",   64'({ifa.first_err_valid, ifa.first_err_vec}), 64'({1'b1, 3'd1}));
    repeat (20) @(negedge clk);
    check("abort.idle",  64'({ifa.busy, ifa.done, ifa.vec_out}), 64'({1'b0, 1'b0, 3'd2}));

    // Abort coincident with the last compare: DONE must not be entered
    bad_a = 8'h00;
    start_a();
    repeat (79) @(negedge clk);
    check("lastab.strobe", 64'({ifa.sample_strobe, ifa.vec_out}), 64'({1'b1, 3'd7}));
    ifa.abort = 1'b1;
    @(negedge clk); ifa.abort = 1'b0;
    check("lastab.flags", 64'({ifa.busy, ifa.done, ifa.pass}), 64'd0);
    repeat (5) @(negedge clk);
    check("lastab.nodone", 64'({ifa.done, ifa.vec_out}), 64'({1'b0, 3'd7}));

    // Saturating counter: every vector mismatches, counter is 2 bits wide
    ref_model(8'hFF, 2, r_err, r_fev, r_valid);
    @(negedge clk); ifs.start = 1'b1;
    @(negedge clk); ifs.start = 1'b0;
    repeat (80) @(negedge clk);
    check("sat.done", 64'(ifs.done), 64'd1);
    check("sat.err",  64'(ifs.err_count), 64'(r_err));
    check("sat.pass", 64'(ifs.pass), 64'd0);
    check("sat.fev",  64'({ifs.first_err_valid, ifs.first_err_vec}), 64'({r_valid, 3'(r_fev)}));

    // HOLD=1: vector advances every cycle, strobe held high
    bad_q = 16'h0200;
    @(negedge clk); ifq.start = 1'b1;
    @(negedge clk); ifq.start = 1'b0;
    cnt = 0;
    for (int t = 0; t <= 16; t++) begin
      if (t < 16) begin
        if (ifq.vec_out !== 4'(t) || ifq.sample_strobe !== 1'b1 || ifq.busy !== 1'b1 || ifq.done !== 1'b0) cnt++;
        @(negedge clk);
      end else begin
        if (ifq.vec_out !== 4'hF || ifq.sample_strobe !== 1'b0 || ifq.busy !== 1'b0 || ifq.done !== 1'b1) cnt++;
      end
    end
    check("fast.trace", 64'(cnt), 64'd0);
    check("fast.err",   64'(ifq.err_count), 64'd1);
    check("fast.fev",   64'({ifq.first_err_valid, ifq.first_err_vec}), 64'({1'b1, 4'd9}));
    check("fast.pass",  64'(ifq.pass), 64'd0);

    // Restart from DONE clears results
    bad_q = '0;
    @(negedge clk); ifq.start = 1'b1;
    @(negedge clk); ifq.start = 1'b0;
    check("fast.restart", 64'({ifq.busy, ifq.done, ifq.first_err_valid, ifq.vec_out, ifq.err_count}),
          64'({1'b1, 1'b0, 1'b0, 4'd0, 16'd0}));
    repeat (16) @(negedge clk);
    check("fast.redone", 64'({ifq.done, ifq.pass, ifq.err_count}), 64'({1'b1, 1'b1, 16'd0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Self-checking stimulus engine, parametrised successor to the hand-written 3-input exhaustive benches.
- Walks every IN_W-bit input combination into a combinational DUT. Holds each vector for HOLD cycles.
- Compares DUT outputs against a golden-model output on the last hold cycle of each vector, then reports error count, first failing vector and pass/fail.
- Instantiated inside benches between the golden model and the DUT; synthesisable so it can also be used for on-board self-test.

Parameters:
- IN_W, 3, width of the driven input vector; sweep length is 2^IN_W vectors; legal range 1..16.
- OUT_W, 2, width of the compared DUT/golden outputs; legal range 1..32.
- HOLD, 10, clock cycles each vector is held; legal range ≥1.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- vec_out  out  IN_W  vector driven to the DUT and golden-model inputs.
- dut_in  in  OUT_W  DUT outputs.
- exp_in  in  OUT_W  golden-model outputs.
- sample_strobe  out  1  high on the compare cycle of each vector.
- busy  out  1  high in DRIVE.
- done  out  1  high in DONE.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  CNT_W  number of mismatching vectors; saturating.
- first_err_vec  out  IN_W  vec_out of the first mismatch; 0 if none.
- first_err_valid  out  1  set on first mismatch; held until next start.

Behaviour:
- Reset (rst_n=0, immediate, asynchronous): state=IDLE, vec_out=0, hold_cnt=0, sample_strobe=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0.
- Reset mid-sweep: discards all progress. No done pulse. A new start is required.
- States:
  - IDLE: outputs hold their values.
  - DRIVE: the sweep runs.
  - DONE: results are held.
- IDLE or DONE, start=1 at edge k, state goes to DRIVE at k. On the same edge, vec_out=0, hold_cnt=0, err_count=0, first_err_vec=0, first_err_valid=0, done=0.
- DRIVE:
  - Each edge, hold_cnt increments.
  - sample_strobe = (state==DRIVE && hold_cnt==HOLD-1), decoded from registered state, no input path.
- Compare cycle, i.e. sample_strobe=1; the DUT has settled for HOLD-1 cycles:
  - Mismatch is dut_in != exp_in, compared bitwise across all OUT_W bits.
  - On mismatch, err_count increments, saturating at 2^CNT_W-1.
  - On mismatch with first_err_valid=0, first_err_vec=vec_out and first_err_valid=1.
  - If vec_out == all-ones, the next edge goes to DONE; vec_out stays all-ones.
  - Otherwise the next edge sets vec_out+1 and hold_cnt=0. No wrap to 0 occurs mid-sweep.
- HOLD=1: every DRIVE cycle is a compare cycle and vec_out advances every cycle.
- Latency:
  - done rises exactly 2^IN_W × HOLD edges after the start edge.
  - Example: IN_W=3, HOLD=10 gives 80 cycles.
- DONE:
  - done=1, busy=0.
  - pass = (err_count==0), registered on entry to DONE.
  - vec_out holds all-ones.
- start in DRIVE is ignored.
- abort=1 at any edge (priority over start): state=IDLE, done=0, pass=0, busy=0. vec_out, err_count and first_err_* keep their values for debug.
- Simultaneous last-vector compare and abort: abort wins and DONE is not entered.
- Mismatch on the final vector is counted before DONE is entered.

Test Plan:
- IN_W=3, HOLD=10, exp_in tied to dut_in, start pulse:
  - vec_out steps 0..7, each held 10 cycles.
  - 8 sample_strobe pulses.
  - done=1 at start+80, pass=1, err_count=0, first_err_valid=0.
- Golden model differs from DUT only for vector 5 and vector 6 → err_count=2, first_err_vec=5, first_err_valid=1, pass=0.
- CNT_W=2, exp_in = ~dut_in for all 8 vectors → err_count saturates at 3; pass=0.
- rst_n pulled low at start+37 (vector 3) → all outputs immediately reset values. After release, no done; a new start gives a full 80-cycle sweep from vector 0.
- abort at start+25 → IDLE next edge, busy=0, done=0, vec_out=2 retained. start pulse mid-sweep in a separate run → ignored, sweep timing unchanged.
- HOLD=1, IN_W=4 → vec_out changes every cycle 0..15, sample_strobe continuously high for 16 cycles, done at start+16. Re-issuing start in DONE clears err_count and restarts the sweep.
